hazard_stall_unit: RTL and testbench

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

---
 rtl/hazard_stall_unit.sv | 162 ++++++++++++++++
 tb/tb_hazard_stall_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard and stall controller.
// Combinational data-hazard detection for the ID stage, plus a small FSM
// that freezes the whole pipeline while the MEM stage waits on data memory.
// A sticky flag records a memory access that exceeded TIMEOUT_CYC wait cycles,
// and a saturating counter tallies every stalled cycle.
module hazard_stall_unit #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        forward_en,
    input  logic [3:0]  src1,
    input  logic [3:0]  src2,
    input  logic        two_src,
    input  logic [3:0]  EXE_dest,
    input  logic [3:0]  MEM_dest,
    input  logic        EXE_WB_en,
    input  logic        MEM_WB_en,
    input  logic        EXE_MEM_R_en,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        hazard,
    output logic        freeze,
    output logic        mem_timeout,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        TIMEOUT = 2'd2
    } state_t;

    // Register 15 is the PC; it is never produced by a pipeline write-back.
    localparam logic [3:0]  PC_REG      = 4'hF;
    localparam logic [7:0]  TIMEOUT_LIM = 8'(TIMEOUT_CYC);
    localparam logic [15:0] STALL_MAX   = 16'hFFFF;

    state_t      state_reg;
    state_t      state_next;
    logic [7:0]  wait_cnt_reg;
    logic [7:0]  wait_cnt_next;
    logic        mem_timeout_reg;
    logic        timeout_set;
    logic [15:0] stall_cnt_reg;
    logic        freeze_comb;
    logic        hazard_comb;

    // Per-source match flags: index 0 is src1, index 1 is src2.
    logic [3:0]  src_num   [2];
    logic [1:0]  src_used;
    logic [1:0]  match_exe;
    logic [1:0]  match_mem;

    assign src_num[0] = src1;
    assign src_num[1] = src2;
    assign src_used   = {two_src, 1'b1};

    // One matcher per source operand against both downstream destinations.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src_match
            logic src_valid;
            assign src_valid     = src_used[gi] && (src_num[gi] != PC_REG);
            assign match_exe[gi] = src_valid && EXE_WB_en && (src_num[gi] == EXE_dest);
            assign match_mem[gi] = src_valid && MEM_WB_en && (src_num[gi] == MEM_dest);
        end
    endgenerate

    // With forwarding only a load in EXE cannot be bypassed in time;
    // without forwarding any pending write-back to a source must drain first.
    always_comb begin
        hazard_comb = 1'b0;
        if (forward_en) begin
            hazard_comb = (|match_exe) && EXE_MEM_R_en;
        end else begin
            hazard_comb = (|match_exe) || (|match_mem);
        end
    end

    assign hazard = hazard_comb;

    // Memory-wait FSM: next state, wait counter and combinational freeze.
    // mem_ready always wins so the pipeline releases in the completion cycle;
    // once waiting, a dropped mem_req is ignored and only mem_ready exits.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        freeze_comb   = 1'b0;
        timeout_set   = 1'b0;
        case (state_reg)
            IDLE: begin
                wait_cnt_next = 8'd0;
                if (mem_req && !mem_ready) begin
                    state_next  = WAIT;
                    freeze_comb = 1'b1;
                end
            end
            WAIT: begin
                if (mem_ready) begin
                    state_next    = IDLE;
                    wait_cnt_next = 8'd0;
                end else begin
                    freeze_comb   = 1'b1;
                    wait_cnt_next = wait_cnt_reg + 8'd1;
                    // Counter never exceeds TIMEOUT_LIM-1 here, so no wrap.
                    if ((wait_cnt_reg + 8'd1) >= TIMEOUT_LIM) begin
                        state_next  = TIMEOUT;
                        timeout_set = 1'b1;
                    end
                end
            end
            TIMEOUT: begin
                if (mem_ready) begin
                    state_next    = IDLE;
                    wait_cnt_next = 8'd0;
                end else begin
                    freeze_comb = 1'b1;
                end
            end
            default: begin
                state_next    = IDLE;
                wait_cnt_next = 8'd0;
            end
        endcase
    end

    assign freeze = freeze_comb;

    // FSM state and wait counter registers; reset overrides every transition.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= 8'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_timeout_reg <= 1'b0;
        end else if (timeout_set) begin
            mem_timeout_reg <= 1'b1;
        end
    end

    assign mem_timeout = mem_timeout_reg;

    // Saturating stall counter; a cycle with both hazard and freeze counts once.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_reg <= 16'd0;
        end else if ((hazard_comb || freeze_comb) && (stall_cnt_reg != STALL_MAX)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Testbench for hazard_stall_unit: table of hazard vectors, hand-written
// memory-wait sequences, counter saturation and a randomized run, all
// compared against a behavioural model of the pipeline rules.
module tb_hazard_stall_unit;

    localparam int TO = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        forward_en = 1'b0;
    logic [3:0]  src1 = 4'd0;
    logic [3:0]  src2 = 4'd0;
    logic        two_src = 1'b0;
    logic [3:0]  EXE_dest = 4'd0;
    logic [3:0]  MEM_dest = 4'd0;
    logic        EXE_WB_en = 1'b0;
    logic        MEM_WB_en = 1'b0;
    logic        EXE_MEM_R_en = 1'b0;
    logic        mem_req = 1'b0;
    logic        mem_ready = 1'b0;
    logic        hazard;
    logic        freeze;
    logic        mem_timeout;
    logic [15:0] stall_cnt;

    int tests = 0;
    int fails = 0;

    // Behavioural model: an access is "outstanding" from an unanswered request
    // until mem_ready; m_waited counts clocks spent waiting after the request.
    bit m_outstanding = 1'b0;
    int m_waited      = 0;
    bit m_timeout     = 1'b0;
    int m_stall       = 0;

    hazard_stall_unit #(.TIMEOUT_CYC(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .forward_en   (forward_en),
        .src1         (src1),
        .src2         (src2),
        .two_src      (two_src),
        .EXE_dest     (EXE_dest),
        .MEM_dest     (MEM_dest),
        .EXE_WB_en    (EXE_WB_en),
        .MEM_WB_en    (MEM_WB_en),
        .EXE_MEM_R_en (EXE_MEM_R_en),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .hazard       (hazard),
        .freeze       (freeze),
        .mem_timeout  (mem_timeout),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       fwd;
        bit [3:0] s1;
        bit [3:0] s2;
        bit       two;
        bit [3:0] ed;
        bit [3:0] md;
        bit       ewb;
        bit       mwb;
        bit       ld;
        bit       exp_h;
    } hz_vec_t;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Which stage (if any) holds an uncommitted write to a register we read.
    function automatic bit ref_hazard();
        bit       on_exe = 1'b0;
        bit       on_mem = 1'b0;
        bit [3:0] r;
        bit       used;
        for (int k = 0; k < 2; k++) begin
            r    = (k == 0) ? src1 : src2;
            used = (k == 0) ? 1'b1 : two_src;
            if (used && r != 4'd15) begin
                if (EXE_WB_en && r == EXE_dest) on_exe = 1'b1;
                if (MEM_WB_en && r == MEM_dest) on_mem = 1'b1;
            end
        end
        if (forward_en) return on_exe && EXE_MEM_R_en;
        return on_exe || on_mem;
    endfunction

    // Pipeline is held whenever memory is busy and has not answered this cycle.
    function automatic bit ref_freeze();
        return !mem_ready && (m_outstanding || mem_req);
    endfunction

    task automatic model_update(input bit stalled);
        if (!rst) begin
            m_outstanding = 1'b0;
            m_waited      = 0;
            m_timeout     = 1'b0;
            m_stall       = 0;
        end else begin
            if (stalled && m_stall < 65535) m_stall++;
            if (mem_ready) begin
                m_outstanding = 1'b0;
                m_waited      = 0;
            end else if (m_outstanding) begin
                m_waited++;
                if (m_waited == TO) m_timeout = 1'b1;
            end else if (mem_req) begin
                m_outstanding = 1'b1;
                m_waited      = 0;
            end
        end
    endtask

    // Called at negedge with inputs already driven; returns at the next negedge.
    task automatic step(input string tag, input bit verbose);
        bit eh;
        bit ef;
        #1;
        eh = ref_hazard();
        ef = ref_freeze();
        if (verbose) begin
            check({tag, ".hazard"}, int'(hazard), int'(eh));
            check({tag, ".freeze"}, int'(freeze), int'(ef));
            check({tag, ".stall_cnt"}, int'(stall_cnt), m_stall);
            check({tag, ".mem_timeout"}, int'(mem_timeout), int'(m_timeout));
            $display("[TB] %s rst=%0b req=%0b rdy=%0b hazard=%0b freeze=%0b stall_cnt=%0d mem_timeout=%0b",
                     tag, rst, mem_req, mem_ready, hazard, freeze, stall_cnt, mem_timeout);
        end
        @(posedge clk);
        model_update(eh || ef);
        @(negedge clk);
    endtask

    task automatic set_hz(input bit fwd, input bit [3:0] s1, input bit [3:0] s2, input bit two,
                          input bit [3:0] ed, input bit [3:0] md, input bit ewb, input bit mwb,
                          input bit ld);
        forward_en = fwd; src1 = s1; src2 = s2; two_src = two;
        EXE_dest = ed; MEM_dest = md; EXE_WB_en = ewb; MEM_WB_en = mwb; EXE_MEM_R_en = ld;
    endtask

    hz_vec_t vecs[12];

    initial begin
        vecs[0]  = '{1, 3, 0, 0, 3, 0, 1, 0, 1, 1};
        vecs[1]  = '{1, 3, 0, 0, 3, 0, 1, 0, 0, 0};
        vecs[2]  = '{0, 0, 5, 0, 0, 5, 0, 1, 0, 0};
        vecs[3]  = '{0, 0, 5, 1, 0, 5, 0, 1, 0, 1};
        vecs[4]  = '{0, 15, 15, 1, 15, 15, 1, 1, 1, 0};
        vecs[5]  = '{1, 2, 7, 1, 9, 2, 1, 1, 0, 0};
        vecs[6]  = '{0, 2, 7, 1, 9, 2, 1, 1, 0, 1};
        vecs[7]  = '{1, 1, 7, 1, 7, 0, 1, 0, 1, 1};
        vecs[8]  = '{1, 1, 7, 0, 7, 0, 1, 0, 1, 0};
        vecs[9]  = '{0, 4, 0, 0, 4, 0, 0, 0, 0, 0};
        vecs[10] = '{0, 6, 0, 0, 1, 6, 0, 1, 0, 1};
        vecs[11] = '{1, 15, 0, 0, 15, 0, 1, 0, 1, 0};

        @(negedge clk);
        // Reset state, and hazard must still evaluate while reset is held.
        rst = 1'b0;
        set_hz(0, 4'd8, 4'd0, 0, 4'd8, 4'd0, 1, 0, 0);
        #1;
        check("reset.hazard_live", int'(hazard), 1);
        step("reset", 1'b1);
        check("reset.stall_cnt", int'(stall_cnt), 0);
        check("reset.mem_timeout", int'(mem_timeout), 0);
        rst = 1'b1;
        set_hz(0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 0, 0, 0);
        step("idle", 1'b1);

        // Table-driven hazard vectors.
        for (int i = 0; i < 12; i++) begin
            set_hz(vecs[i].fwd, vecs[i].s1, vecs[i].s2, vecs[i].two, vecs[i].ed,
                   vecs[i].md, vecs[i].ewb, vecs[i].mwb, vecs[i].ld);
            #1;
            check($sformatf("vec%0d.hazard_table", i), int'(hazard), int'(vecs[i].exp_h));
            step($sformatf("vec%0d", i), 1'b1);
        end

        // Four-cycle memory wait then ready; with TO=3 it also times out.
        rst = 1'b0;
        set_hz(0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 0, 0, 0);
        step("rst2", 1'b1);
        rst = 1'b1;
        mem_req = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("wait%0d.freeze", i), int'(freeze), 1);
            step($sformatf("wait%0d", i), 1'b1);
            check($sformatf("wait%0d.mem_timeout", i), int'(mem_timeout), (i == 3) ? 1 : 0);
        end
        mem_req = 1'b0;
        step("req_dropped", 1'b1);
        mem_ready = 1'b1;
        #1;
        check("ready.freeze", int'(freeze), 0);
        step("ready", 1'b1);
        check("ready.stall_cnt", int'(stall_cnt), 5);
        mem_ready = 1'b0;
        #1;
        check("after_ready.freeze_idle", int'(freeze), 0);
        check("after_ready.mem_timeout_sticky", int'(mem_timeout), 1);
        step("after_ready", 1'b1);

        // Single-cycle access: request answered immediately never freezes.
        mem_req = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("single.freeze", int'(freeze), 0);
        step("single", 1'b1);
        mem_req = 1'b0;
        mem_ready = 1'b0;
        step("single_after", 1'b1);

        // Saturate the stall counter with a held hazard.
        set_hz(0, 4'd1, 4'd0, 0, 4'd1, 4'd0, 1, 0, 0);
        for (int i = 0; i < 65540; i++) step("sat", 1'b0);
        step("sat_hold", 1'b1);
        check("sat.stall_cnt", int'(stall_cnt), 65535);
        step("sat_hold2", 1'b1);
        check("sat2.stall_cnt", int'(stall_cnt), 65535);

        // Enter WAIT, then reset for one edge.
        set_hz(0, 4'd2, 4'd0, 0, 4'd1, 4'd0, 1, 0, 0);
        mem_req = 1'b1;
        step("to_wait", 1'b1);
        step("in_wait", 1'b1);
        rst = 1'b0;
        mem_req = 1'b0;
        step("mid_wait_rst", 1'b1);
        rst = 1'b1;
        #1;
        check("post_rst.freeze", int'(freeze), 0);
        check("post_rst.stall_cnt", int'(stall_cnt), 0);
        check("post_rst.mem_timeout", int'(mem_timeout), 0);
        step("post_rst", 1'b1);

        // Randomized run against the model.
        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
            forward_en   = 1'($urandom_range(0, 1));
            src1         = 4'($urandom_range(0, 15));
            src2         = 4'($urandom_range(0, 15));
            two_src      = 1'($urandom_range(0, 1));
            EXE_dest     = ($urandom_range(0, 2) == 0) ? src1 : 4'($urandom_range(0, 15));
            MEM_dest     = ($urandom_range(0, 2) == 0) ? src2 : 4'($urandom_range(0, 15));
            EXE_WB_en    = 1'($urandom_range(0, 1));
            MEM_WB_en    = 1'($urandom_range(0, 1));
            EXE_MEM_R_en = 1'($urandom_range(0, 1));
            mem_req      = ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0;
            mem_ready    = ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0;
            step($sformatf("rand%0d", i), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
